// File: rtl/uart1_rx_pkg.sv
// Shared UART1 definitions: FSM states, default geometry and line levels.
// Imported by receiver-side RTL.
package uart1_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

  localparam logic BIT_START = 1'b0;
  localparam logic BIT_STOP  = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart1_rx_if.sv
// Valid/ready byte port between the UART1 receiver and its consumer.
// master = receiver, slave = consumer.
interface uart1_rx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart1_rx_sync.sv
// Serial line synchronizer plus registered falling-edge detect.
// Flops reset to the idle level so release never fakes a start bit.
module uart1_sync
  import uart1_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic rxs,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   fall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{LINE_IDLE}};
      prev_q <= LINE_IDLE;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign fall = fall_q;

endmodule

// File: rtl/uart1_rx.sv
// UART1 receiver: 8N1-style frame recovery with mid-bit sampling,
// valid/ready byte output, framing-error and overrun pulses.
module uart1_rx
  import uart1_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int SYNC_STAGES  = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     serial_in,
  uart1_rx_if.master rx,
  output logic     frame_err,
  output logic     overrun,
  output logic     parallel_out_active
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rxs;
  logic fall;

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  uart1_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .serial_in(serial_in),
    .rxs      (rxs),
    .fall     (fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx.rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = START;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = (rxs == BIT_START) ? DATA : IDLE;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs;
          bit_d          = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          // A held byte blocks the new one unless it is taken this edge
          if (rxs != BIT_STOP) begin
            ferr_d = 1'b1;
          end else if (!valid_q || rx.rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx.rx_data          = data_q;
  assign rx.rx_valid         = valid_q;
  assign frame_err           = ferr_q;
  assign overrun             = ovr_q;
  assign parallel_out_active = (state_q != IDLE);

endmodule

// File: tb/tb_uart1_rx.sv
// Directed bench for uart1_rx: table of frames plus hand-built
// sequences for latency, glitch, break, overrun and mid-frame reset.
module tb_uart1_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int SS  = 2;
  localparam int LAT = SS + 1 + CPB / 2 + (DB + 1) * CPB;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;
  logic frame_err;
  logic overrun;
  logic parallel_out_active;

  uart1_rx_if #(.DATA_BITS(DB)) rx ();

  uart1_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .SYNC_STAGES (SS)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .serial_in          (serial_in),
    .rx                 (rx.master),
    .frame_err          (frame_err),
    .overrun            (overrun),
    .parallel_out_active(parallel_out_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int vc  = 0;
  int fe  = 0;
  int ov  = 0;
  int act = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (rx.rx_valid) vc++;
      if (frame_err) fe++;
      if (overrun) ov++;
      if (parallel_out_active) act++;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       rdy;
    int         e_vc;
    logic [7:0] e_d;
    int         e_fe;
    int         e_ov;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    serial_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < DB; i++) begin
      serial_in = d[i];
      idle(CPB);
    end
    serial_in = stop;
    idle(CPB);
  endtask

  int b_vc, b_fe, b_ov, b_act, lat;
  bit seen;

  initial begin
    tbl[0] = '{8'h00, 1'b1, 1'b1, 1, 8'h00, 0, 0};
    tbl[1] = '{8'hFF, 1'b1, 1'b1, 1, 8'hFF, 0, 0};
    tbl[2] = '{8'h3C, 1'b0, 1'b1, 0, 8'hFF, 1, 0};
    tbl[3] = '{8'h81, 1'b1, 1'b1, 1, 8'h81, 0, 0};
    tbl[4] = '{8'hC3, 1'b1, 1'b1, 1, 8'hC3, 0, 0};

    rst         = 1'b0;
    serial_in   = 1'b1;
    rx.rx_ready = 1'b1;
    idle(3);
    chk("rst_valid", int'(rx.rx_valid), 0);
    chk("rst_data", int'(rx.rx_data), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_active", int'(parallel_out_active), 0);
    rst = 1'b1;
    idle(50);
    chk("rel_active", act, 0);
    chk("rel_valid", vc, 0);

    // 0xBA with latency measurement
    b_vc = vc; b_fe = fe;
    lat = 0; seen = 1'b0;
    fork
      send_frame(8'hBA, 1'b1);
      begin
        @(posedge clk);
        while (!seen && lat < 400) begin
          @(posedge clk);
          lat++;
          #1;
          if (rx.rx_valid) seen = 1'b1;
        end
      end
    join
    idle(20);
    chk("ba_latency", lat, LAT);
    chk("ba_data", int'(rx.rx_data), 8'hBA);
    chk("ba_vcyc", vc - b_vc, 1);
    chk("ba_ferr", fe - b_fe, 0);

    foreach (tbl[k]) begin
      b_vc = vc; b_fe = fe; b_ov = ov;
      rx.rx_ready = tbl[k].rdy;
      send_frame(tbl[k].d, tbl[k].stop);
      serial_in = 1'b1;
      idle(30);
      chk($sformatf("tbl%0d_vcyc", k), vc - b_vc, tbl[k].e_vc);
      chk($sformatf("tbl%0d_data", k), int'(rx.rx_data), int'(tbl[k].e_d));
      chk($sformatf("tbl%0d_ferr", k), fe - b_fe, tbl[k].e_fe);
      chk($sformatf("tbl%0d_ovr", k), ov - b_ov, tbl[k].e_ov);
    end

    // glitch shorter than half a bit
    b_vc = vc; b_fe = fe; b_act = act;
    serial_in = 1'b0;
    idle(4);
    serial_in = 1'b1;
    idle(10);
    chk("gl_active_now", int'(parallel_out_active), 0);
    chk("gl_active_seen", int'(act > b_act), 1);
    chk("gl_vcyc", vc - b_vc, 0);
    chk("gl_ferr", fe - b_fe, 0);

    // bad stop, line held low, then a good frame
    b_vc = vc; b_fe = fe;
    send_frame(8'h3C, 1'b0);
    b_act = act;
    idle(40);
    chk("brk_active", act - b_act, 0);
    chk("brk_ferr", fe - b_fe, 1);
    chk("brk_vcyc", vc - b_vc, 0);
    serial_in = 1'b1;
    idle(20);
    send_frame(8'h55, 1'b1);
    idle(20);
    chk("brk_55_data", int'(rx.rx_data), 8'h55);
    chk("brk_55_vcyc", vc - b_vc, 1);

    // overrun: consumer stalled across two frames
    b_ov = ov; b_fe = fe;
    rx.rx_ready = 1'b0;
    send_frame(8'h12, 1'b1);
    idle(20);
    send_frame(8'h34, 1'b1);
    idle(20);
    chk("ov_data", int'(rx.rx_data), 8'h12);
    chk("ov_valid", int'(rx.rx_valid), 1);
    chk("ov_pulse", ov - b_ov, 1);
    chk("ov_ferr", fe - b_fe, 0);
    rx.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ov_drop", int'(rx.rx_valid), 0);
    idle(5);

    // reset during data bit 3 with a byte held
    rx.rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    idle(20);
    chk("pre_valid", int'(rx.rx_valid), 1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(CPB * 4 + CPB / 2);
        rst = 1'b0;
        #1;
        chk("mr_valid", int'(rx.rx_valid), 0);
        chk("mr_data", int'(rx.rx_data), 0);
        chk("mr_active", int'(parallel_out_active), 0);
        chk("mr_ferr", int'(frame_err | overrun), 0);
        idle(3);
        rst = 1'b1;
      end
    join
    idle(20);
    b_vc = vc; b_fe = fe; b_ov = ov;
    rx.rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    idle(20);
    chk("a5_data", int'(rx.rx_data), 8'hA5);
    chk("a5_vcyc", vc - b_vc, 1);
    chk("a5_err", (fe - b_fe) + (ov - b_ov), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
